// File: rtl/op2_fetch_stage_pkg.sv
// Shared definitions for the operand-2 fetch stage: source select codes
// and the layout of a buffered entry {err, is_bit, value}.
package op2_fetch_stage_pkg;

    // Width of the op2_sel field coming from decode.
    localparam int OP2_SEL_LEN = 3;

    // Operand-2 source select codes; 5..7 are not assigned and flag an error.
    localparam logic [OP2_SEL_LEN-1:0] OP2_SEL_INPUT   = 3'd0;
    localparam logic [OP2_SEL_LEN-1:0] OP2_SEL_OUTPUT  = 3'd1;
    localparam logic [OP2_SEL_LEN-1:0] OP2_SEL_BITRAM  = 3'd2;
    localparam logic [OP2_SEL_LEN-1:0] OP2_SEL_BYTERAM = 3'd3;
    localparam logic [OP2_SEL_LEN-1:0] OP2_SEL_IMM     = 3'd4;

    // An entry carries two flag bits on top of the operand value.
    localparam int ENTRY_META_W = 2;

    // Entry width for a given operand width: {err, is_bit, value[data_w-1:0]}.
    function automatic int entry_w(input int data_w);
        return data_w + ENTRY_META_W;
    endfunction

endpackage

// File: rtl/op2_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush.
// M (main) drives the outputs, S (skid) absorbs the one entry accepted
// while the consumer stalls, so in_ready can be a plain register.
module op2_skid_buf #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]       state_r;
    logic [1:0]       next_state_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] m_data_r;
    logic [WIDTH-1:0] s_data_r;
    logic             accept_s;
    logic             pop_s;
    logic             load_m_s;
    logic             m_from_s_s;
    logic             load_s_s;

    assign accept_s  = in_valid & in_ready_r;
    assign pop_s     = out_valid_r & out_ready;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = m_data_r;

    // Next-state and register-load decode; flush overrides every transition
    // and suppresses any load, while a same-cycle pop simply completes.
    always_comb begin
        next_state_s = state_r;
        load_m_s     = 1'b0;
        m_from_s_s   = 1'b0;
        load_s_s     = 1'b0;
        if (flush) begin
            next_state_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        next_state_s = ST_ONE;
                        load_m_s     = 1'b1;
                    end else begin
                        next_state_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && pop_s) begin
                        next_state_s = ST_ONE;
                        load_m_s     = 1'b1;
                    end else if (accept_s) begin
                        next_state_s = ST_TWO;
                        load_s_s     = 1'b1;
                    end else if (pop_s) begin
                        next_state_s = ST_EMPTY;
                    end else begin
                        next_state_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a pop can move us.
                    if (pop_s) begin
                        next_state_s = ST_ONE;
                        load_m_s     = 1'b1;
                        m_from_s_s   = 1'b1;
                    end else begin
                        next_state_s = ST_TWO;
                    end
                end
                default: begin
                    next_state_s = ST_EMPTY;
                end
            endcase
        end
    end

    // Occupancy state plus registered handshake flags derived from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= next_state_s;
            out_valid_r <= (next_state_s != ST_EMPTY);
            in_ready_r  <= (next_state_s != ST_TWO);
        end
    end

    // Entry storage; registers change only on a load so a stalled output holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_data_r <= '0;
            s_data_r <= '0;
        end else begin
            if (load_m_s) begin
                m_data_r <= m_from_s_s ? s_data_r : in_data;
            end
            if (load_s_s) begin
                s_data_r <= in_data;
            end
        end
    end

endmodule

// File: rtl/op2_fetch_stage.sv
// Operand-2 fetch stage: picks operand 2 from one of five sources, applies
// optional bit extraction and the negate modifier, and hands the result to
// the ALU through a 2-entry skid buffer.
module op2_fetch_stage
    import op2_fetch_stage_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OP2_SEL_LEN-1:0] op2_sel,
    input  logic                   neg_mod,
    input  logic                   bit_ext,
    input  logic [IDX_W-1:0]       bit_idx,
    input  logic                   input_rd,
    input  logic                   output_rd,
    input  logic                   bit_rd,
    input  logic [DATA_W-1:0]      byte_rd,
    input  logic [DATA_W-1:0]      imm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      op2_out,
    output logic                   op2_is_bit,
    output logic                   sel_err
);

    localparam int          ENTRY_W  = entry_w(DATA_W);
    localparam logic [31:0] DATA_W_U = 32'(DATA_W);

    logic [DATA_W-1:0]  word_s;
    logic [DATA_W-1:0]  value_s;
    logic               is_bit_s;
    logic               err_s;
    logic [31:0]        idx_wide_s;
    logic               idx_oor_s;
    logic [ENTRY_W-1:0] entry_in_s;
    logic [ENTRY_W-1:0] entry_out_s;

    // A bit index past the top of the word can only occur when DATA_W is not
    // a power of two; it is caught rather than reading a nonexistent bit.
    assign idx_wide_s = {{(32-IDX_W){1'b0}}, bit_idx};
    assign idx_oor_s  = (idx_wide_s >= DATA_W_U);

    // Operand formation: source mux, bit extraction, then negate (skipped on error).
    always_comb begin
        word_s   = '0;
        value_s  = '0;
        is_bit_s = 1'b0;
        err_s    = 1'b0;
        case (op2_sel)
            OP2_SEL_INPUT: begin
                value_s  = {{(DATA_W-1){1'b0}}, input_rd};
                is_bit_s = 1'b1;
            end
            OP2_SEL_OUTPUT: begin
                value_s  = {{(DATA_W-1){1'b0}}, output_rd};
                is_bit_s = 1'b1;
            end
            OP2_SEL_BITRAM: begin
                value_s  = {{(DATA_W-1){1'b0}}, bit_rd};
                is_bit_s = 1'b1;
            end
            OP2_SEL_BYTERAM, OP2_SEL_IMM: begin
                word_s = (op2_sel == OP2_SEL_IMM) ? imm : byte_rd;
                if (bit_ext) begin
                    if (idx_oor_s) begin
                        err_s = 1'b1;
                    end else begin
                        value_s  = {{(DATA_W-1){1'b0}}, word_s[bit_idx]};
                        is_bit_s = 1'b1;
                    end
                end else begin
                    value_s = word_s;
                end
            end
            default: begin
                err_s = 1'b1;
            end
        endcase

        if (err_s) begin
            value_s  = '0;
            is_bit_s = 1'b0;
        end else if (neg_mod) begin
            if (is_bit_s) begin
                value_s[0] = ~value_s[0];
            end else begin
                value_s = ~value_s;
            end
        end else begin
            value_s = value_s;
        end
    end

    assign entry_in_s = {err_s, is_bit_s, value_s};

    op2_skid_buf #(
        .WIDTH (ENTRY_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (entry_in_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (entry_out_s)
    );

    assign sel_err    = entry_out_s[ENTRY_W-1];
    assign op2_is_bit = entry_out_s[ENTRY_W-2];
    assign op2_out    = entry_out_s[DATA_W-1:0];

endmodule

// File: tb/tb_op2_fetch_stage.sv
// Directed self-checking bench for op2_fetch_stage. Inputs are driven and
// outputs sampled 1 time unit after the rising edge.
module tb_op2_fetch_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op2_sel;
    logic       neg_mod;
    logic       bit_ext;
    logic [2:0] bit_idx;
    logic       input_rd;
    logic       output_rd;
    logic       bit_rd;
    logic [7:0] byte_rd;
    logic [7:0] imm;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] op2_out;
    logic       op2_is_bit;
    logic       sel_err;

    int errors = 0;
    int checks = 0;
    logic [10:0] obs;

    op2_fetch_stage #(.DATA_W(8), .IDX_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op2_sel    (op2_sel),
        .neg_mod    (neg_mod),
        .bit_ext    (bit_ext),
        .bit_idx    (bit_idx),
        .input_rd   (input_rd),
        .output_rd  (output_rd),
        .bit_rd     (bit_rd),
        .byte_rd    (byte_rd),
        .imm        (imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .op2_out    (op2_out),
        .op2_is_bit (op2_is_bit),
        .sel_err    (sel_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request on the decode side.
    task automatic drive(input logic [2:0] sel, input logic neg, input logic ext,
                         input logic [2:0] idx, input logic b_in, input logic b_out,
                         input logic b_ram, input logic [7:0] byt, input logic [7:0] im);
        in_valid  = 1'b1;
        op2_sel   = sel;
        neg_mod   = neg;
        bit_ext   = ext;
        bit_idx   = idx;
        input_rd  = b_in;
        output_rd = b_out;
        bit_rd    = b_ram;
        byte_rd   = byt;
        imm       = im;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(3'd3, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF);
        in_valid = 1'b0;
        step(); step();
        obs = {out_valid, sel_err, op2_is_bit, op2_out};
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++; $display("FAIL reset_outputs: got %h want %h", obs, {1'b0, 1'b0, 1'b0, 8'h00});
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_byte_basic();
        out_ready = 1'b1;
        drive(3'd3, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h00);
        step();
        in_valid = 1'b0;
        obs = {out_valid, sel_err, op2_is_bit, op2_out};
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, 8'hA5}) begin
            errors++; $display("FAIL byte_a5: got %h want %h", obs, {1'b1, 1'b0, 1'b0, 8'hA5});
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL byte_drain: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_sources_neg();
        out_ready = 1'b1;
        drive(3'd2, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        step();
        obs = {out_valid, sel_err, op2_is_bit, op2_out};
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b1, 8'h00}) begin
            errors++; $display("FAIL bitram_neg: got %h want %h", obs, {1'b1, 1'b0, 1'b1, 8'h00});
        end
        drive(3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h0F, 8'h00);
        step();
        obs = {out_valid, sel_err, op2_is_bit, op2_out};
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, 8'hF0}) begin
            errors++; $display("FAIL byte_neg: got %h want %h", obs, {1'b1, 1'b0, 1'b0, 8'hF0});
        end
        drive(3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF);
        step();
        obs = {out_valid, sel_err, op2_is_bit, op2_out};
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b1, 8'h01}) begin
            errors++; $display("FAIL input_bit: got %h want %h", obs, {1'b1, 1'b0, 1'b1, 8'h01});
        end
        drive(3'd1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF);
        step();
        obs = {out_valid, sel_err, op2_is_bit, op2_out};
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b1, 8'h01}) begin
            errors++; $display("FAIL output_bit_neg: got %h want %h", obs, {1'b1, 1'b0, 1'b1, 8'h01});
        end
        // bit_ext is ignored for a bit source.
        drive(3'd2, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        step();
        obs = {out_valid, sel_err, op2_is_bit, op2_out};
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b1, 8'h01}) begin
            errors++; $display("FAIL bitram_ext_ignored: got %h want %h", obs, {1'b1, 1'b0, 1'b1, 8'h01});
        end
    endtask

    task automatic test_bit_ext();
        out_ready = 1'b1;
        drive(3'd4, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 8'hFF, 8'b0010_0000);
        step();
        obs = {out_valid, sel_err, op2_is_bit, op2_out};
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b1, 8'h01}) begin
            errors++; $display("FAIL imm_ext5: got %h want %h", obs, {1'b1, 1'b0, 1'b1, 8'h01});
        end
        drive(3'd4, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 8'hFF, 8'b0010_0000);
        step();
        obs = {out_valid, sel_err, op2_is_bit, op2_out};
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b1, 8'h00}) begin
            errors++; $display("FAIL imm_ext6: got %h want %h", obs, {1'b1, 1'b0, 1'b1, 8'h00});
        end
        drive(3'd4, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 8'hFF, 8'b0010_0000);
        step();
        obs = {out_valid, sel_err, op2_is_bit, op2_out};
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b1, 8'h01}) begin
            errors++; $display("FAIL imm_ext6_neg: got %h want %h", obs, {1'b1, 1'b0, 1'b1, 8'h01});
        end
        drive(3'd3, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 8'h80, 8'h00);
        step();
        obs = {out_valid, sel_err, op2_is_bit, op2_out};
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b1, 8'h01}) begin
            errors++; $display("FAIL byte_ext7: got %h want %h", obs, {1'b1, 1'b0, 1'b1, 8'h01});
        end
    endtask

    task automatic test_sel_err();
        out_ready = 1'b1;
        drive(3'd6, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF);
        step();
        obs = {out_valid, sel_err, op2_is_bit, op2_out};
        checks++;
        if (obs !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
            errors++; $display("FAIL sel6: got %h want %h", obs, {1'b1, 1'b1, 1'b0, 8'h00});
        end
        drive(3'd7, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF);
        step();
        obs = {out_valid, sel_err, op2_is_bit, op2_out};
        checks++;
        if (obs !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
            errors++; $display("FAIL sel7_neg: got %h want %h", obs, {1'b1, 1'b1, 1'b0, 8'h00});
        end
        drive(3'd5, 1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF);
        step();
        obs = {out_valid, sel_err, op2_is_bit, op2_out};
        checks++;
        if (obs !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
            errors++; $display("FAIL sel5_ext_neg: got %h want %h", obs, {1'b1, 1'b1, 1'b0, 8'h00});
        end
        drive(3'd4, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h3C);
        step();
        in_valid = 1'b0;
        obs = {out_valid, sel_err, op2_is_bit, op2_out};
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, 8'h3C}) begin
            errors++; $display("FAIL err_clear: got %h want %h", obs, {1'b1, 1'b0, 1'b0, 8'h3C});
        end
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(3'd4, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h11);
        step();
        checks++;
        if ({in_ready, out_valid, op2_out} !== {1'b1, 1'b1, 8'h11}) begin
            errors++; $display("FAIL b2b_a_loaded: got %h want %h", {in_ready, out_valid, op2_out}, {1'b1, 1'b1, 8'h11});
        end
        drive(3'd4, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h22);
        step();
        checks++;
        if ({in_ready, out_valid, op2_out} !== {1'b0, 1'b1, 8'h11}) begin
            errors++; $display("FAIL b2b_full: got %h want %h", {in_ready, out_valid, op2_out}, {1'b0, 1'b1, 8'h11});
        end
        drive(3'd4, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h33);
        step(); step();
        checks++;
        if ({in_ready, out_valid, op2_out} !== {1'b0, 1'b1, 8'h11}) begin
            errors++; $display("FAIL b2b_stall_hold: got %h want %h", {in_ready, out_valid, op2_out}, {1'b0, 1'b1, 8'h11});
        end
        out_ready = 1'b1;
        step();
        checks++;
        if ({in_ready, out_valid, op2_out} !== {1'b1, 1'b1, 8'h22}) begin
            errors++; $display("FAIL b2b_second: got %h want %h", {in_ready, out_valid, op2_out}, {1'b1, 1'b1, 8'h22});
        end
        step();
        in_valid = 1'b0;
        checks++;
        if ({in_ready, out_valid, op2_out} !== {1'b1, 1'b1, 8'h33}) begin
            errors++; $display("FAIL b2b_third: got %h want %h", {in_ready, out_valid, op2_out}, {1'b1, 1'b1, 8'h33});
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_no_dup: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(3'd4, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h44);
        step();
        drive(3'd4, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h55);
        step();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_setup_full: got in_ready=%b want 0", in_ready);
        end
        drive(3'd4, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h66);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++; $display("FAIL flush_empty: got %b want 10", {in_ready, out_valid});
        end
        // The request presented during flush is dropped even though in_ready is high now.
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        checks++;
        if ({out_valid, op2_out} !== {1'b0, 8'h44}) begin
            errors++; $display("FAIL flush_dropped: got %h want %h", {out_valid, op2_out}, {1'b0, 8'h44});
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(3'd3, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h77, 8'h00);
        step(); step();
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        obs = {out_valid, sel_err, op2_is_bit, op2_out};
        checks++;
        if ({in_ready, obs} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++; $display("FAIL reset_mid: got %h want %h", {in_ready, obs}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        end
        step();
        reset = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_no_partial: got out_valid=%b want 0", out_valid);
        end
        out_ready = 1'b1;
        drive(3'd3, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h00);
        step();
        in_valid = 1'b0;
        obs = {out_valid, sel_err, op2_is_bit, op2_out};
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, 8'h5A}) begin
            errors++; $display("FAIL after_reset: got %h want %h", obs, {1'b1, 1'b0, 1'b0, 8'h5A});
        end
        step();
    endtask

    initial begin
        test_reset();
        test_byte_basic();
        test_sources_neg();
        test_bit_ext();
        test_sel_err();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
